// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the HDMI pixel-clock PLL reconfiguration sequencer.
// Holds the sequencer state type, the reconfiguration-controller register map,
// and helpers that build counter words in the controller's layout.
package pll_cfg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrMode,
    StWrN,
    StWrM,
    StWrC,
    StWrK,
    StWrStart,
    StWaitLock,
    StDone,
    StErr
  } state_e;

  // Reconfiguration controller register addresses
  localparam logic [5:0] AddrMode   = 6'd0;
  localparam logic [5:0] AddrStatus = 6'd1;
  localparam logic [5:0] AddrStart  = 6'd2;
  localparam logic [5:0] AddrN      = 6'd3;
  localparam logic [5:0] AddrM      = 6'd4;
  localparam logic [5:0] AddrC      = 6'd5;
  localparam logic [5:0] AddrK      = 6'd7;

  // Counter word field offsets
  localparam int unsigned CntOddBit    = 17;
  localparam int unsigned CntBypassBit = 16;
  localparam int unsigned CntHiLsb     = 8;
  localparam int unsigned CntLoLsb     = 0;

  localparam logic [4:0] CntSelC0 = 5'd0;

  // Build an 18-bit counter word from its fields.
  function automatic logic [17:0] pack_cnt(input logic odd, input logic bypass,
                                           input logic [7:0] hi, input logic [7:0] lo);
    logic [17:0] w;
    w = '0;
    w[CntOddBit]         = odd;
    w[CntBypassBit]      = bypass;
    w[CntHiLsb +: 8]     = hi;
    w[CntLoLsb +: 8]     = lo;
    return w;
  endfunction

  // C-counter register data: counter select sits just above the counter word.
  function automatic logic [31:0] c_word(input logic [4:0] sel, input logic [17:0] cnt);
    return {9'd0, sel, cnt};
  endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (async active-low), clr (synchronous clear of both flops),
//        din (asynchronous input), dout (synchronized output).
module jtframe_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else if (clr) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign dout = sync_q[1];

endmodule

// File: rtl/pll_hdmi_cfg.sv
// Run-time reprogramming sequencer for the HDMI pixel-clock PLL.
// On req it latches the N/M/C0/K settings, writes them to the PLL reconfiguration
// controller over Avalon-MM (waitrequest mode), starts reconfiguration and waits
// for the PLL to re-lock, reporting done or err as a one-cycle pulse.
// Ports:
//   clk, rst_n                 management clock, async active-low reset
//   req                        start pulse, only accepted when idle
//   cfg_n/cfg_m/cfg_c0/cfg_k   new counter words and fractional K
//   busy, done, err            sequencer status
//   mgmt_*                     Avalon-MM master towards the reconfig controller
//   pll_locked                 PLL lock, asynchronous to clk
module pll_hdmi_cfg
  import pll_cfg_pkg::*;
#(
  parameter logic [23:0] LOCK_TMO    = 24'd5_000_000,
  parameter logic [15:0] LOCK_SETTLE = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam logic [23:0] TmoLast    = LOCK_TMO - 24'd1;
  localparam logic [15:0] SettleLast = LOCK_SETTLE - 16'd1;

  state_e      state_q;
  logic [17:0] n_q, m_q, c0_q;
  logic [31:0] k_q;
  logic [23:0] tmo_q;
  logic [15:0] settle_q;
  logic        locked_s;

  // Lock status seen before reconfiguration is stale, so the synchronizer is
  // held clear until the sequencer is actually waiting for the new lock.
  jtframe_sync2 u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != StWaitLock),
    .din  (pll_locked),
    .dout (locked_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      n_q            <= '0;
      m_q            <= '0;
      c0_q           <= '0;
      k_q            <= '0;
      tmo_q          <= '0;
      settle_q       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            n_q            <= cfg_n;
            m_q            <= cfg_m;
            c0_q           <= cfg_c0;
            k_q            <= cfg_k;
            busy           <= 1'b1;
            mgmt_write     <= 1'b1;
            mgmt_address   <= AddrMode;
            mgmt_writedata <= 32'd0;  // waitrequest mode
            state_q        <= StWrMode;
          end
        end
        StWrMode: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= AddrN;
            mgmt_writedata <= {14'd0, n_q};
            state_q        <= StWrN;
          end
        end
        StWrN: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= AddrM;
            mgmt_writedata <= {14'd0, m_q};
            state_q        <= StWrM;
          end
        end
        StWrM: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= AddrC;
            mgmt_writedata <= c_word(CntSelC0, c0_q);
            state_q        <= StWrC;
          end
        end
        StWrC: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= AddrK;
            mgmt_writedata <= k_q;
            state_q        <= StWrK;
          end
        end
        StWrK: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= AddrStart;
            mgmt_writedata <= 32'd1;
            state_q        <= StWrStart;
          end
        end
        StWrStart: begin
          if (!mgmt_waitrequest) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            tmo_q          <= '0;
            settle_q       <= '0;
            state_q        <= StWaitLock;
          end
        end
        StWaitLock: begin
          tmo_q    <= tmo_q + 24'd1;
          settle_q <= locked_s ? settle_q + 16'd1 : 16'd0;
          // Settle is tested first so a simultaneous timeout still reports done.
          if (locked_s && (settle_q == SettleLast)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else if (tmo_q == TmoLast) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StErr;
          end
        end
        StDone, StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_hdmi_cfg.sv
module tb_pll_hdmi_cfg;
  import pll_cfg_pkg::*;

  localparam int Settle = 20;
  localparam int Tmo    = 100;
  localparam int MaxC   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0;
  logic [31:0] cfg_k = '0;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;

  always #5 clk = ~clk;

  pll_hdmi_cfg #(
    .LOCK_TMO   (24'd100),
    .LOCK_SETTLE(16'd20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .cfg_n           (cfg_n),
    .cfg_m           (cfg_m),
    .cfg_c0          (cfg_c0),
    .cfg_k           (cfg_k),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .mgmt_address    (mgmt_address),
    .mgmt_write      (mgmt_write),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked      (pll_locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus schedule (cycle 0 = cycle in which req is driven)
  logic lk_pat [MaxC];
  logic wr_pat [MaxC];
  logic rq_pat [MaxC];
  int   stall  [6];
  logic [17:0] n0, m0, c00;
  logic [31:0] k0;

  // Observed trace
  logic        o_busy [MaxC];
  logic        o_done [MaxC];
  logic        o_err  [MaxC];
  logic        o_wr   [MaxC];
  logic [5:0]  o_addr [MaxC];
  logic [31:0] o_data [MaxC];

  // Reference model results
  int          m_w, m_done, m_err, m_end;
  logic [5:0]  m_addr [6];
  logic [31:0] m_data [6];

  // Features extracted from the observed trace
  int          s_nw, s_ndone, s_done, s_nerr, s_err, s_fall;
  logic        s_rebusy;
  logic [5:0]  s_addr   [8];
  logic [31:0] s_data   [8];
  int          s_hold   [8];
  logic        s_stable [8];

  function automatic logic [17:0] rnd_cnt();
    return pack_cnt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom));
  endfunction

  task automatic new_cfg();
    n0  = rnd_cnt();
    m0  = rnd_cnt();
    c00 = rnd_cnt();
    k0  = $urandom;
  endtask

  task automatic set_stalls(input bit random_on);
    for (int i = 0; i < 6; i++) stall[i] = random_on ? int'($urandom_range(0, 3)) : 0;
  endtask

  // Waitrequest schedule from the stall counts; lock high and no extra req by default.
  task automatic build_sched();
    int t;
    for (int c = 0; c < MaxC; c++) begin
      wr_pat[c] = 1'b0;
      lk_pat[c] = 1'b1;
      rq_pat[c] = 1'b0;
    end
    t = 1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < stall[i]; j++) wr_pat[t + j] = 1'b1;
      t += 1 + stall[i];
    end
    m_w = t;
  endtask

  // Expected register writes and completion cycle. Lock is honoured once it has
  // been seen high for Settle consecutive cycles from the start of the wait; the
  // synchronizer adds two cycles and the done pulse one more.
  task automatic model();
    int run;
    m_addr = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2};
    m_data[0] = 32'd0;
    m_data[1] = {14'd0, n0};
    m_data[2] = {14'd0, m0};
    m_data[3] = {14'd0, c00};
    m_data[4] = k0;
    m_data[5] = 32'd1;
    m_done = -1;
    m_err  = -1;
    run    = 0;
    for (int x = m_w; x + 3 <= m_w + Tmo; x++) begin
      run = lk_pat[x] ? run + 1 : 0;
      if (run == Settle) begin
        m_done = x + 3;
        break;
      end
    end
    if (m_done < 0) m_err = m_w + Tmo;
    m_end = (m_done >= 0) ? m_done : m_err;
  endtask

  // Drives one transaction from IDLE and records outputs for cycles 0..ncyc.
  // After cycle 0 the cfg inputs are scrambled every cycle.
  task automatic run_txn(input int ncyc);
    for (int c = 0; c <= ncyc; c++) begin
      o_busy[c] = busy;
      o_done[c] = done;
      o_err[c]  = err;
      o_wr[c]   = mgmt_write;
      o_addr[c] = mgmt_address;
      o_data[c] = mgmt_writedata;
      if (c == ncyc) break;
      req = (c == 0) || rq_pat[c];
      if (c == 0) begin
        cfg_n = n0; cfg_m = m0; cfg_c0 = c00; cfg_k = k0;
      end else begin
        cfg_n = rnd_cnt(); cfg_m = rnd_cnt(); cfg_c0 = rnd_cnt(); cfg_k = $urandom;
      end
      mgmt_waitrequest = wr_pat[c];
      pll_locked       = lk_pat[c];
      @(posedge clk);
      #1;
    end
    req              = 1'b0;
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic summarize(input int ncyc);
    int          hold;
    logic        stab;
    logic [5:0]  ra;
    logic [31:0] rd;
    s_nw = 0; s_ndone = 0; s_done = -1; s_nerr = 0; s_err = -1; s_fall = -1;
    s_rebusy = 1'b0;
    hold = 0; stab = 1'b1; ra = '0; rd = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (o_wr[c]) begin
        if (hold == 0) begin
          ra = o_addr[c];
          rd = o_data[c];
        end else if (o_addr[c] !== ra || o_data[c] !== rd) begin
          stab = 1'b0;
        end
        hold++;
        if (!wr_pat[c]) begin
          if (s_nw < 8) begin
            s_addr[s_nw] = ra; s_data[s_nw] = rd; s_hold[s_nw] = hold; s_stable[s_nw] = stab;
          end
          s_nw++;
          hold = 0;
          stab = 1'b1;
        end
      end
      if (o_done[c]) begin
        if (s_ndone == 0) s_done = c;
        s_ndone++;
      end
      if (o_err[c]) begin
        if (s_nerr == 0) s_err = c;
        s_nerr++;
      end
      if (s_fall >= 0) begin
        if (o_busy[c]) s_rebusy = 1'b1;
      end else if (!o_busy[c]) begin
        s_fall = c;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = 1'($urandom); cfg_n = rnd_cnt(); cfg_m = rnd_cnt(); cfg_c0 = rnd_cnt();
      cfg_k = $urandom; mgmt_waitrequest = 1'($urandom); pll_locked = 1'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, err, mgmt_write, mgmt_address, mgmt_writedata} !== 41'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b err=%b wr=%b addr=%0d data=%h, want all 0",
                 i, busy, done, err, mgmt_write, mgmt_address, mgmt_writedata);
      end
    end
    req = 1'b0; mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    new_cfg(); set_stalls(1'b0); build_sched(); model();
    run_txn(m_end + 3); summarize(m_end + 3);
    n_checks++;
    if (s_nw !== 6) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 6", s_nw); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (s_addr[i] !== m_addr[i] || s_data[i] !== m_data[i] || s_hold[i] !== 1) begin
        n_fail++;
        $display("FAIL basic_write[%0d]: got (%0d,%h) hold %0d, want (%0d,%h) hold 1",
                 i, s_addr[i], s_data[i], s_hold[i], m_addr[i], m_data[i]);
      end
    end
    n_checks++;
    if (s_done !== 9 + Settle || s_ndone !== 1 || s_nerr !== 0) begin
      n_fail++;
      $display("FAIL basic_done: got cycle %0d (%0d done, %0d err), want cycle %0d once",
               s_done, s_ndone, s_nerr, 9 + Settle);
    end
    n_checks++;
    if (s_fall !== s_done || s_rebusy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy fell at %0d (rebusy %b), want %0d", s_fall, s_rebusy, 9 + Settle);
    end
  endtask

  task automatic test_stall();
    new_cfg(); set_stalls(1'b0); stall[2] = 3; build_sched(); model();
    run_txn(m_end + 3); summarize(m_end + 3);
    n_checks++;
    if (s_hold[2] !== 4 || s_stable[2] !== 1'b1 || s_addr[2] !== 6'd4 || s_data[2] !== m_data[2]) begin
      n_fail++;
      $display("FAIL stall_wr_m: got hold %0d stable %b (%0d,%h), want hold 4 stable 1 (4,%h)",
               s_hold[2], s_stable[2], s_addr[2], s_data[2], m_data[2]);
    end
    n_checks++;
    if (s_nw !== 6 || s_addr[5] !== 6'd2 || s_data[3] !== m_data[3]) begin
      n_fail++;
      $display("FAIL stall_sequence: got %0d writes last addr %0d, want 6 writes last addr 2",
               s_nw, s_addr[5]);
    end
    n_checks++;
    if (s_done !== 12 + Settle || s_ndone !== 1) begin
      n_fail++;
      $display("FAIL stall_done: got cycle %0d (%0d pulses), want %0d", s_done, s_ndone, 12 + Settle);
    end
    // Random stalls on every write
    for (int it = 0; it < 3; it++) begin
      new_cfg(); set_stalls(1'b1); build_sched(); model();
      run_txn(m_end + 3); summarize(m_end + 3);
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (s_addr[i] !== m_addr[i] || s_data[i] !== m_data[i] || s_hold[i] !== 1 + stall[i] ||
            s_stable[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL rstall_write[%0d.%0d]: got (%0d,%h) hold %0d stable %b, want (%0d,%h) hold %0d",
                   it, i, s_addr[i], s_data[i], s_hold[i], s_stable[i], m_addr[i], m_data[i],
                   1 + stall[i]);
        end
      end
      n_checks++;
      if (s_done !== m_done || s_ndone !== 1) begin
        n_fail++;
        $display("FAIL rstall_done[%0d]: got cycle %0d, want %0d", it, s_done, m_done);
      end
    end
  endtask

  task automatic test_lock_glitch();
    for (int it = 0; it < 4; it++) begin
      int g;
      new_cfg(); set_stalls(it != 0); build_sched();
      g = int'($urandom_range(2, Settle - 2));
      lk_pat[m_w + g] = 1'b0;
      if (it == 3) lk_pat[m_w + g + 1] = 1'b0;
      model();
      run_txn(m_end + 3); summarize(m_end + 3);
      n_checks++;
      if (s_done !== m_done || s_ndone !== 1 || s_nerr !== 0) begin
        n_fail++;
        $display("FAIL glitch_done[%0d]: got cycle %0d (%0d done, %0d err), want %0d",
                 it, s_done, s_ndone, s_nerr, m_done);
      end
    end
  endtask

  task automatic test_timeout();
    new_cfg(); set_stalls(1'b1); build_sched();
    for (int c = 0; c < MaxC; c++) lk_pat[c] = 1'b0;
    model();
    run_txn(m_end + 3); summarize(m_end + 3);
    n_checks++;
    if (s_err !== m_w + Tmo || s_nerr !== 1) begin
      n_fail++;
      $display("FAIL timeout_err: got cycle %0d (%0d pulses), want %0d", s_err, s_nerr, m_w + Tmo);
    end
    n_checks++;
    if (s_ndone !== 0) begin n_fail++; $display("FAIL timeout_nodone: got %0d done, want 0", s_ndone); end
    n_checks++;
    if (s_fall !== m_w + Tmo) begin
      n_fail++;
      $display("FAIL timeout_busy: fell at %0d, want %0d", s_fall, m_w + Tmo);
    end
  endtask

  // Lock rising just in time for settle and timeout to expire together, then one cycle late.
  task automatic test_tie();
    for (int late = 0; late < 2; late++) begin
      int r;
      new_cfg(); set_stalls(1'b0); build_sched();
      r = m_w + Tmo - Settle - 2 + late;
      for (int c = 0; c < r; c++) lk_pat[c] = 1'b0;
      model();
      run_txn(m_end + 3); summarize(m_end + 3);
      n_checks++;
      if (late == 0 && (s_done !== m_w + Tmo || s_nerr !== 0)) begin
        n_fail++;
        $display("FAIL tie_done: got done %0d err count %0d, want done %0d no err",
                 s_done, s_nerr, m_w + Tmo);
      end else if (late == 1 && (s_err !== m_w + Tmo || s_ndone !== 0)) begin
        n_fail++;
        $display("FAIL tie_late_err: got err %0d done count %0d, want err %0d no done",
                 s_err, s_ndone, m_w + Tmo);
      end
    end
  endtask

  task automatic test_busy_req();
    new_cfg(); set_stalls(1'b0); build_sched();
    rq_pat[5] = 1'b1;
    model();
    run_txn(m_end + 30); summarize(m_end + 30);
    n_checks++;
    if (s_nw !== 6 || s_data[4] !== k0) begin
      n_fail++;
      $display("FAIL busyreq_k: got %0d writes k=%h, want 6 writes k=%h", s_nw, s_data[4], k0);
    end
    n_checks++;
    if (s_ndone !== 1 || s_done !== m_done || s_rebusy !== 1'b0) begin
      n_fail++;
      $display("FAIL busyreq_done: got %0d done at %0d rebusy %b, want 1 at %0d",
               s_ndone, s_done, s_rebusy, m_done);
    end
  endtask

  task automatic test_back_to_back();
    new_cfg(); set_stalls(1'b1); build_sched(); model();
    rq_pat[m_end] = 1'b1;  // req in the done cycle
    run_txn(m_end + 1); summarize(m_end + 1);
    n_checks++;
    if (s_done !== m_done || o_busy[m_end + 1] !== 1'b0 || o_wr[m_end + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_req: done at %0d busy after %b wr after %b, want done %0d busy 0 wr 0",
               s_done, o_busy[m_end + 1], o_wr[m_end + 1], m_done);
    end
    new_cfg(); set_stalls(1'b1); build_sched(); model();
    run_txn(m_end + 3); summarize(m_end + 3);
    n_checks++;
    if (s_nw !== 6 || s_data[1] !== m_data[1] || s_data[4] !== m_data[4] || s_done !== m_done) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d writes n=%h k=%h done %0d, want 6 n=%h k=%h done %0d",
               s_nw, s_data[1], s_data[4], s_done, m_data[1], m_data[4], m_done);
    end
  endtask

  task automatic test_async_reset();
    new_cfg(); set_stalls(1'b0); build_sched(); model();
    run_txn(4);
    n_checks++;
    if (o_wr[4] !== 1'b1 || o_addr[4] !== 6'd5) begin
      n_fail++;
      $display("FAIL areset_pre: got wr=%b addr=%0d, want wr=1 addr=5", o_wr[4], o_addr[4]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mgmt_write !== 1'b0 || busy !== 1'b0 || mgmt_address !== 6'd0) begin
      n_fail++;
      $display("FAIL areset_now: got wr=%b busy=%b addr=%0d, want 0 0 0", mgmt_write, busy, mgmt_address);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || mgmt_write !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: got busy=%b wr=%b, want 0 0", busy, mgmt_write);
    end
    new_cfg(); set_stalls(1'b0); build_sched(); model();
    run_txn(m_end + 3); summarize(m_end + 3);
    n_checks++;
    if (s_nw !== 6 || s_addr[0] !== 6'd0 || s_data[3] !== m_data[3] || s_done !== 9 + Settle) begin
      n_fail++;
      $display("FAIL areset_rerun: got %0d writes first addr %0d c=%h done %0d, want 6 0 %h %0d",
               s_nw, s_addr[0], s_data[3], s_done, m_data[3], 9 + Settle);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_lock_glitch();
    test_timeout();
    test_tie();
    test_busy_req();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
